// File: rtl/ucsbece152a_ctrl_pkg.sv
// Shared types and helpers for the counter run/stop/step controller.
package ucsbece152a_ctrl_pkg;

  typedef enum logic [1:0] {STOP, RUN, STEP} state_t;

  function automatic int unsigned presc_width(input int unsigned tick_div);
    return $clog2(tick_div);
  endfunction

endpackage

// File: rtl/ucsbece152a_btn_sync.sv
// Button conditioner: 2-FF synchroniser followed by a registered rising-edge detect.
// A raw high sampled at edge N yields pulse_o high for the single cycle after edge N+2.
module ucsbece152a_btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  logic [2:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync    <= '0;
      pulse_o <= 1'b0;
    end else begin
      sync    <= {sync[1:0], btn_i};
      pulse_o <= sync[1] & ~sync[2];
    end
  end

endmodule

// File: rtl/ucsbece152a_counter_ctrl.sv
// Run/stop/single-step sequencer producing enable pulses and direction for the display counter.
// Optional bounce mode (ping-pong at 0/MAX): define UCSBECE152A_COUNTER_CTRL_BOUNCE_EN.
module ucsbece152a_counter_ctrl #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned TICK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             step_i,
  input  logic             dir_toggle_i,
  input  logic [WIDTH-1:0] count_i,
  output logic             enable_o,
  output logic             dir_o,
  output logic             running_o
);

  import ucsbece152a_ctrl_pkg::*;

  localparam int unsigned    PW   = presc_width(TICK_DIV);
  localparam logic [PW-1:0]  LAST = PW'(TICK_DIV - 1);

  logic start_ev, stop_ev, step_ev, toggle_ev;

  ucsbece152a_btn_sync u_start  (.clk(clk), .rst(rst), .btn_i(start_i),      .pulse_o(start_ev));
  ucsbece152a_btn_sync u_stop   (.clk(clk), .rst(rst), .btn_i(stop_i),       .pulse_o(stop_ev));
  ucsbece152a_btn_sync u_step   (.clk(clk), .rst(rst), .btn_i(step_i),       .pulse_o(step_ev));
  ucsbece152a_btn_sync u_toggle (.clk(clk), .rst(rst), .btn_i(dir_toggle_i), .pulse_o(toggle_ev));

  state_t        state;
  logic [PW-1:0] presc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= STOP;
      presc     <= '0;
      running_o <= 1'b0;
    end else begin
      case (state)
        STOP: begin
          presc <= '0;
          // stop > start > step; a stop event while stopped swallows the others
          if (!stop_ev) begin
            if (start_ev) begin
              state     <= RUN;
              running_o <= 1'b1;
            end else if (step_ev) begin
              state <= STEP;
            end
          end
        end
        RUN: begin
          if (stop_ev) begin
            state     <= STOP;
            presc     <= '0;
            running_o <= 1'b0;
          end else begin
            presc <= (presc == LAST) ? '0 : presc + PW'(1);
          end
        end
        STEP: begin
          state <= STOP;
        end
        default: begin
          state     <= STOP;
          presc     <= '0;
          running_o <= 1'b0;
        end
      endcase
    end
  end

  assign enable_o = (state == STEP) || ((state == RUN) && (presc == LAST));

`ifdef UCSBECE152A_COUNTER_CTRL_BOUNCE_EN
  localparam logic [WIDTH-1:0] MAX = '1;

  // Limit reversal takes precedence over a coincident toggle event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_o <= 1'b1;
    end else if (!enable_o && dir_o && (count_i == MAX)) begin
      dir_o <= 1'b0;
    end else if (!enable_o && !dir_o && (count_i == '0)) begin
      dir_o <= 1'b1;
    end else if (toggle_ev) begin
      dir_o <= ~dir_o;
    end
  end
`else
  logic unused_count;
  assign unused_count = ^count_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_o <= 1'b1;
    end else if (toggle_ev) begin
      dir_o <= ~dir_o;
    end
  end
`endif

endmodule

// File: tb/tb_ucsbece152a_counter_ctrl.sv
// Scoreboard bench for ucsbece152a_counter_ctrl; behavioural model also drives count_i as the counter.
module tb_ucsbece152a_counter_ctrl;

  localparam int unsigned WIDTH = 3;
  localparam int unsigned TD    = 4;
  localparam int unsigned MAXV  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i, stop_i, step_i, dir_toggle_i;
  logic [WIDTH-1:0] count_i;
  logic             enable_o, dir_o, running_o;

  always #5 clk = ~clk;

  ucsbece152a_counter_ctrl #(.WIDTH(WIDTH), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .step_i(step_i),
    .dir_toggle_i(dir_toggle_i), .count_i(count_i),
    .enable_o(enable_o), .dir_o(dir_o), .running_o(running_o)
  );

  typedef struct packed {logic en; logic dir; logic run;} exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Model: running flag, pending single step, cycles since RUN entry, direction, counter value.
  bit          m_run, m_step, m_dir;
  int unsigned m_phase, m_cnt;
  bit [4:0]    hist[4];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_enable();
    return m_step || (m_run && (m_phase % TD == TD - 1));
  endfunction

  function automatic void model_reset();
    m_run = 0; m_step = 0; m_dir = 1; m_phase = 0;
    for (int i = 0; i < 4; i++) hist[i] = '0;
  endfunction

  function automatic void model_edge(input bit st, input bit sp, input bit stp, input bit tg);
    bit [3:0]    raw;
    bit [3:0]    ev;
    bit          en_pre, bounced;
    int unsigned cnt_pre;
    raw = {tg, stp, sp, st};
    // Event visible at this edge = rising edge of the raw sample taken three edges earlier.
    for (int i = 0; i < 4; i++) begin
      hist[i] = {hist[i][3:0], raw[i]};
      ev[i]   = hist[i][3] & ~hist[i][4];
    end
    en_pre  = m_enable();
    cnt_pre = m_cnt;
    if (en_pre) m_cnt = m_dir ? (m_cnt + 1) % (MAXV + 1) : (m_cnt + MAXV) % (MAXV + 1);
    bounced = 0;
`ifdef UCSBECE152A_COUNTER_CTRL_BOUNCE_EN
    if (!en_pre && m_dir && cnt_pre == MAXV) begin m_dir = 0; bounced = 1; end
    else if (!en_pre && !m_dir && cnt_pre == 0) begin m_dir = 1; bounced = 1; end
`endif
    if (!bounced && ev[3]) m_dir = !m_dir;
    if (m_step) begin
      m_step = 0;
    end else if (m_run) begin
      if (ev[1]) begin m_run = 0; m_phase = 0; end
      else m_phase = m_phase + 1;
    end else if (!ev[1]) begin
      if (ev[0]) begin m_run = 1; m_phase = 0; end
      else if (ev[2]) m_step = 1;
    end
  endfunction

  task automatic cyc(input bit st, input bit sp, input bit stp, input bit tg);
    start_i = st; stop_i = sp; step_i = stp; dir_toggle_i = tg;
    @(posedge clk); #1;
    model_edge(st, sp, stp, tg);
    sb.push_back('{en: m_enable(), dir: m_dir, run: m_run});
    count_i = WIDTH'(m_cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic load(input int unsigned v);
    m_cnt = v; count_i = WIDTH'(v);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("enable_o", enable_o, e.en);
        chk("dir_o", dir_o, e.dir);
        chk("running_o", running_o, e.run);
      end
    end
  end

  initial begin : stim
    bit found;
    rst = 1; start_i = 0; stop_i = 0; step_i = 0; dir_toggle_i = 0; count_i = '0;
    m_cnt = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_enable", enable_o, 1'b0);
    chk("rst_dir", dir_o, 1'b1);
    chk("rst_running", running_o, 1'b0);
    rst = 0;

    // Held start gives a single event; pulses every TD cycles.
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
    idle(14);
    // Simultaneous stop and start while running.
    cyc(1, 1, 0, 0);
    idle(10);
    // Three isolated single steps.
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0);
      idle(9);
    end
    // Wrap (or bounce) from 6 upward, then reverse mid-run.
    load(6);
    if (!m_dir) begin cyc(0, 0, 0, 1); idle(5); end
    cyc(1, 0, 0, 0);
    idle(16);
    cyc(0, 0, 0, 1);
    idle(12);
    cyc(0, 1, 0, 0);
    idle(6);
    // Long run from 0 with a toggle dropped in.
    load(0);
    idle(4);
    cyc(1, 0, 0, 0);
    idle(30);
    cyc(0, 0, 0, 1);
    idle(50);
    cyc(0, 1, 0, 0);
    idle(6);

    // Asynchronous reset while an enable pulse is high.
    cyc(1, 0, 0, 0);
    found = 0;
    for (int i = 0; i < 4 * TD + 8 && !found; i++) begin
      cyc(0, 0, 0, 0);
      found = m_enable();
    end
    chk("rst_window_found", found, 1'b1);
    sb.delete();
    if (found) chk("pre_rst_enable", enable_o, 1'b1);
    #1 rst = 1;
    #1;
    chk("async_enable", enable_o, 1'b0);
    chk("async_dir", dir_o, 1'b1);
    chk("async_running", running_o, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
    idle(10);
    cyc(1, 0, 0, 0);
    idle(12);

    // Randomised button activity with occasional counter reloads while stopped.
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 11) == 0, $urandom_range(0, 29) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 13) == 0);
      if (!m_run && !m_step && $urandom_range(0, 63) == 0) load($urandom_range(0, MAXV));
    end

    idle(2);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
